// File: rtl/nba_recurrence_engine.sv
// Iterative engine for the recurrence a <- b + c, d <- a - 3, b <- d + 10.
// Every update in an iteration reads pre-iteration values; operands and results move over valid/ready handshakes.
module nba_recurrence_engine #(
    parameter int WIDTH = 32,
    parameter int ITERS = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic signed [WIDTH-1:0] in_c,
    input  logic signed [WIDTH-1:0] in_d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_a,
    output logic signed [WIDTH-1:0] out_b,
    output logic signed [WIDTH-1:0] out_c,
    output logic signed [WIDTH-1:0] out_d,
    output logic                    busy,
    output logic [CNT_W-1:0]        iter_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]        ITERS_C = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic signed [WIDTH-1:0] SUB_C   = WIDTH'(3);
    localparam logic signed [WIDTH-1:0] ADD_C   = WIDTH'(10);
    localparam logic signed [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t                  state_r;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [WIDTH-1:0] c_r;
    logic signed [WIDTH-1:0] d_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    last_iter_s;

    // Post-edge iteration count and the decision whether this RUN edge is the last one.
    always_comb begin
        cnt_inc_s   = cnt_r + CNT_ONE;
        last_iter_s = 1'b0;
        if (cnt_inc_s == ITERS_C) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // Control FSM, datapath registers and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= DATA_ZERO;
            b_r         <= DATA_ZERO;
            c_r         <= DATA_ZERO;
            d_r         <= DATA_ZERO;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        c_r        <= in_c;
                        d_r        <= in_d;
                        cnt_r      <= CNT_ZERO;
                        in_ready_r <= 1'b0;
                        // A zero-iteration run presents the loaded set directly.
                        if (ITERS_C == CNT_ZERO) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            state_r     <= RUN;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_r   <= b_r + c_r;
                    d_r   <= a_r - SUB_C;
                    b_r   <= d_r + ADD_C;
                    cnt_r <= cnt_inc_s;
                    if (last_iter_s) begin
                        state_r     <= HOLD;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign iter_cnt  = cnt_r;
    assign out_a     = a_r;
    assign out_b     = b_r;
    assign out_c     = c_r;
    assign out_d     = d_r;

endmodule
